// File: rtl/micro_seq_engine_pkg.sv
// Shared types for the microcoded sequencer.
// Default widths, sequencer opcodes, FSM states and microword layout.
package micro_seq_pkg;

  localparam int MS_CTRL_W  = 20;
  localparam int MS_OPC_W   = 5;
  localparam int MS_UADDR_W = 8;
  localparam int MS_LOOP_W  = 6;

  typedef enum logic [2:0] {
    SEQ_NEXT  = 3'd0,
    SEQ_LDCNT = 3'd1,
    SEQ_LOOP  = 3'd2,
    SEQ_JUMP  = 3'd3,
    SEQ_MEMRD = 3'd4,
    SEQ_MEMWR = 3'd5,
    SEQ_END   = 3'd6,
    SEQ_RSVD  = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_MEM_WAIT,
    ST_DONE
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic [MS_CTRL_W-1:0]  ctrl;
    seq_op_e               op;
    logic [MS_UADDR_W-1:0] target;
  } microword_t;

endpackage

// File: rtl/micro_seq_engine_if.sv
// Decode handshake, AHB qualifiers and microcode write port
// bundled between the sequencer and its environment.
interface micro_seq_engine_if #(
  parameter int CTRL_W  = 20,
  parameter int OPC_W   = 5,
  parameter int UADDR_W = 8
);
  localparam int WORD_W = CTRL_W + 3 + UADDR_W;

  logic               id_rf_valid_inst;
  logic [OPC_W-1:0]   decode_addr;
  logic               ready;
  logic [CTRL_W-1:0]  current_control;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic               HREADY;
  logic               rf_valid_inst;
  logic               done;
  logic               uc_we;
  logic [UADDR_W-1:0] uc_waddr;
  logic [WORD_W-1:0]  uc_wdata;

  modport master (
    output id_rf_valid_inst, decode_addr, HREADY,
    output uc_we, uc_waddr, uc_wdata,
    input  ready, current_control, HTRANS, HWRITE,
    input  rf_valid_inst, done
  );

  modport slave (
    input  id_rf_valid_inst, decode_addr, HREADY,
    input  uc_we, uc_waddr, uc_wdata,
    output ready, current_control, HTRANS, HWRITE,
    output rf_valid_inst, done
  );

endinterface

// File: rtl/micro_seq_engine_uc_store.sv
// Microcode store: one synchronous write port,
// one combinational read port, contents not reset.
module uc_store #(
  parameter int AW = 8,
  parameter int DW = 31
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/micro_seq_engine.sv
// Microcoded sequencer: fetches one microword per cycle, drives
// the RF control word and AHB qualifiers, retires with done.
module micro_seq_engine
  import micro_seq_pkg::*;
#(
  parameter int CTRL_W  = MS_CTRL_W,
  parameter int OPC_W   = MS_OPC_W,
  parameter int UADDR_W = MS_UADDR_W,
  parameter int LOOP_W  = MS_LOOP_W
) (
  input logic               clk,
  input logic               rst,
  micro_seq_engine_if.slave bus
);

  localparam int WORD_W = CTRL_W + 3 + UADDR_W;

  state_e             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [UADDR_W-1:0] upc_inc;
  logic [UADDR_W-1:0] entry;
  logic [LOOP_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0]  word;
  logic [CTRL_W-1:0]  w_ctrl;
  seq_op_e            w_op;
  logic [UADDR_W-1:0] w_tgt;
  logic               exec;
  logic               uc_wen;

  assign uc_wen  = bus.uc_we && (state_q == ST_IDLE);
  assign upc_inc = upc_q + 1'b1;
  assign entry   = {bus.decode_addr, {(UADDR_W-OPC_W){1'b0}}};

  uc_store #(
    .AW (UADDR_W),
    .DW (WORD_W)
  ) u_store (
    .clk     (clk),
    .we_i    (uc_wen),
    .waddr_i (bus.uc_waddr),
    .wdata_i (bus.uc_wdata),
    .raddr_i (upc_q),
    .rdata_o (word)
  );

  assign w_ctrl = word[WORD_W-1 -: CTRL_W];
  assign w_op   = seq_op_e'(word[UADDR_W +: 3]);
  assign w_tgt  = word[UADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    upc_d               = upc_q;
    cnt_d               = cnt_q;
    exec                = 1'b0;
    bus.ready           = 1'b0;
    bus.current_control = '0;
    bus.HTRANS          = HTRANS_IDLE;
    bus.HWRITE          = 1'b0;
    bus.done            = 1'b0;
    bus.rf_valid_inst   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.ready = 1'b1;
        if (bus.id_rf_valid_inst) begin
          upc_d   = entry;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN:      exec = 1'b1;
      ST_MEM_WAIT: exec = bus.HREADY;
      ST_DONE: begin
        bus.done          = 1'b1;
        bus.rf_valid_inst = 1'b1;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A MEM_WAIT word with HREADY high behaves exactly like RUN
    if (exec) begin
      bus.current_control = w_ctrl;
      state_d             = ST_RUN;
      unique case (w_op)
        SEQ_NEXT: upc_d = upc_inc;
        SEQ_LDCNT: begin
          cnt_d = w_tgt[LOOP_W-1:0];
          upc_d = upc_inc;
        end
        SEQ_LOOP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            upc_d = w_tgt;
          end else begin
            upc_d = upc_inc;
          end
        end
        SEQ_JUMP: upc_d = w_tgt;
        SEQ_MEMRD, SEQ_MEMWR: begin
          bus.HTRANS = HTRANS_NONSEQ;
          bus.HWRITE = (w_op == SEQ_MEMWR);
          upc_d      = upc_inc;
          state_d    = ST_MEM_WAIT;
        end
        default: state_d = ST_DONE;
      endcase
    end
  end

endmodule

// File: doc/micro_seq_engine.md
Name: micro_seq_engine

Overview:
Parametrised microcoded sequencer that drives the register-file control word, the AHB-style transfer qualifiers and the instruction-complete handshake. It is the generalised successor of the fixed micro-controller. Control-word width, microcode depth, opcode width and loop-counter width are all parameters. Additions over the fixed controller: writable microcode, a hardware loop counter for bit-serial iteration, jumps, and HREADY-stalled memory accesses.

Parameters:
CTRL_W, 20, width of the control word sent to the register file
OPC_W, 5, width of decode_addr
UADDR_W, 8, micro-PC width; depth is 2**UADDR_W; must be > OPC_W
LOOP_W, 6, loop-counter width; must be <= UADDR_W

Ports:
clk  in  1  clock
rst  in  1  reset
id_rf_valid_inst  in  1  start request from decode
decode_addr  in  OPC_W  opcode; entry uPC = {decode_addr, zeros(UADDR_W-OPC_W)}
ready  out  1  high only in IDLE; a start is accepted when ready && id_rf_valid_inst
current_control  out  CTRL_W  control word to the register file
HTRANS  out  2  00 IDLE, 10 NONSEQ
HWRITE  out  1  write qualifier, valid when HTRANS=10
HREADY  in  1  bus ready
rf_valid_inst  out  1  instruction retired pulse
done  out  1  same cycle as rf_valid_inst
uc_we  in  1  microcode write strobe
uc_waddr  in  UADDR_W  microcode write address
uc_wdata  in  CTRL_W+3+UADDR_W  microword {ctrl, seq_op[2:0], target}

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high. Reset forces IDLE, uPC=0, cnt=0, current_control=0, HTRANS=00, HWRITE=0, done=0, rf_valid_inst=0, ready=1. Microcode storage is not reset.
- IDLE: all outputs 0 except ready=1. On start: uPC <= entry, cnt <= 0, go to RUN. The first microword drives its outputs the cycle after acceptance.
- RUN: one microword per cycle. current_control = word.ctrl, combinational from storage. seq_op actions:
  - NEXT (0): uPC+1.
  - LDCNT (1): cnt <= target[LOOP_W-1:0]; uPC+1.
  - LOOP (2): if cnt!=0 then cnt-1 and uPC<=target; else uPC+1. A word that loops to itself with load value N executes N+1 times.
  - JUMP (3): uPC <= target.
  - MEMRD (4) / MEMWR (5): this cycle HTRANS=10, HWRITE=(op==MEMWR); uPC+1; go to MEM_WAIT.
  - END (6): uPC held; go to DONE.
  - Code 7 is reserved and behaves as END.
- MEM_WAIT: HTRANS=00, HWRITE=0.
  - HREADY=0: current_control=0, uPC frozen.
  - HREADY=1: the word at uPC executes exactly as in RUN (ctrl driven, seq_op applied), so it performs the data-phase capture. Next state is per that word; a MEMRD/MEMWR word issues back-to-back and stays in MEM_WAIT.
- DONE: for one cycle done=1, rf_valid_inst=1, current_control=0, ready=0; then IDLE.
- Wrap-around: uPC+1 from 2**UADDR_W-1 wraps to 0. cnt never underflows.
- uc_we is honoured only in IDLE and ignored in every other state. A write and a start in the same IDLE cycle: the write lands at that edge, so the first fetch sees the new data.
- id_rf_valid_inst while not IDLE is ignored; upstream holds it until ready.
- rst mid-operation, including MEM_WAIT: the bus transfer is abandoned and IDLE is entered next cycle with no done.

Decomposition:
- Package micro_seq_pkg holds: seq_op_e (NEXT..END), state_e (IDLE, RUN, MEM_WAIT, DONE), HTRANS_IDLE/HTRANS_NONSEQ constants, and a packed microword_t struct parameterised through localparams matching the defaults.
- One sub-module, uc_store: 2**UADDR_W x microword register array with one synchronous write port and one combinational read port.

Test Plan:
- Loop: load 0x08={ctrl 0x00010, LDCNT, 3}, 0x09={0x00002, LOOP, 0x09}, 0x0A={0x00001, END}; start decode_addr=1 -> current_control 0x00010, then 0x00002 x4, then 0x00001, then done=rf_valid_inst=1 for one cycle, then ready=1.
- Read stall: 0x10={0x00100, MEMRD}, 0x11={0x00400, END}; start decode_addr=2 with HREADY low 2 cycles -> HTRANS=10, HWRITE=0 one cycle; then current_control=0 for 2 cycles; 0x00400 in the HREADY=1 cycle; done next cycle.
- Write, zero wait: same program with MEMWR and HREADY=1 -> HWRITE=1 with HTRANS=10; 0x00400 the very next cycle.
- Reset in MEM_WAIT: rst=1 one cycle -> next cycle all outputs 0, ready=1, done never asserted; a rerun produces the identical sequence.
- Busy protection: id_rf_valid_inst and uc_we pulsed during RUN -> no restart; stored words unchanged (read back via a rerun).
- Wrap: 0xFF={0x00007, NEXT}, 0x00={0x00003, END}; JUMP to 0xFF -> 0x00007, 0x00003, done.
